// File: rtl/note_judge.sv
// Rhythm-game judging stage: steps through the note chart one slot at a time
// and grades key hits against the opening window of each note slot.
module note_judge #(
  parameter int TICKS_PER_SLOT = 25,
  parameter int WINDOW         = 8,
  parameter int ADDR_W         = 8,
  parameter int SCORE_W        = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               map,
  input  logic               tick,
  input  logic               hit,
  output logic [ADDR_W-1:0]  chart_addr,
  input  logic [1:0]         chart_data,
  output logic               good,
  output logic               miss,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo
);

  localparam int SW = $clog2(TICKS_PER_SLOT + 1);
  localparam int WW = $clog2(WINDOW + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(TICKS_PER_SLOT - 1);
  localparam logic [SW-1:0] SLOT_FULL = SW'(TICKS_PER_SLOT);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPEN,
    S_GAP,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [7:0]          combo_q, combo_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [WW-1:0]       win_q, win_d;
  logic                good_q, good_d;
  logic                miss_q, miss_d;
  logic                done_q, done_d;
  logic                slot_end;

  // A window as long as the slot leaves GAP already at the full count.
  assign slot_end = (slot_q == SLOT_FULL) ||
                    (tick && slot_q == SLOT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    score_d = score_q;
    combo_d = combo_q;
    slot_d  = slot_q;
    win_d   = win_q;
    good_d  = 1'b0;
    miss_d  = 1'b0;
    done_d  = 1'b0;
    if (!map && state_q != S_IDLE) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          addr_d = '0;
          if (map) begin
            score_d = '0;
            combo_d = '0;
            slot_d  = '0;
            win_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          slot_d = '0;
          win_d  = '0;
          if (chart_data[1]) begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else if (chart_data[0]) begin
            state_d = S_OPEN;
          end else begin
            state_d = S_GAP;
          end
        end
        S_OPEN: begin
          if (tick) begin
            slot_d = slot_q + SW'(1);
            win_d  = win_q + WW'(1);
          end
          if (hit) begin
            good_d  = 1'b1;
            score_d = (score_q == '1) ? score_q
                                      : score_q + SCORE_W'(1);
            combo_d = (combo_q == 8'hff) ? combo_q
                                         : combo_q + 8'd1;
            state_d = S_GAP;
          end else if (tick && win_q == WIN_LAST) begin
            miss_d  = 1'b1;
            combo_d = '0;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (slot_end) begin
            if (addr_q == '1) begin
              done_d  = 1'b1;
              state_d = S_FINISH;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end else if (tick) begin
            slot_d = slot_q + SW'(1);
          end
        end
        S_FINISH: state_d = S_FINISH;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
      slot_q  <= '0;
      win_q   <= '0;
      good_q  <= 1'b0;
      miss_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      score_q <= score_d;
      combo_q <= combo_d;
      slot_q  <= slot_d;
      win_q   <= win_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      done_q  <= done_d;
    end
  end

  assign chart_addr = addr_q;
  assign good       = good_q;
  assign miss       = miss_q;
  assign done       = done_q;
  assign score      = score_q;
  assign combo      = combo_q;

endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Upstream judging stage of the rhythm-game core. It walks the note chart in fixed time slots and judges player hits against a timing window.
- Its outputs are one-cycle pulses: `good` on a hit, `miss` on an expired window, `done` at chart end. `miss` and `done` feed the game-state controller, which counts misses and picks win/lose.
- It runs only while the controller's `map` output is high. It returns to idle whenever `map` drops (lose, win, or quit), from any state.

Parameters:
- TICKS_PER_SLOT, 25, number of `tick` pulses per chart slot; must be >= WINDOW.
- WINDOW, 8, number of `tick` pulses after slot start during which a hit counts; must be >= 1.
- ADDR_W, 8, chart address width.
- SCORE_W, 10, score counter width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- map  in  1  game-running enable from the game-state controller.
- tick  in  1  one-cycle timebase pulse, e.g. 60 Hz.
- hit  in  1  one-cycle pulse from the key edge detector.
- chart_addr  out  ADDR_W  address into the chart ROM.
- chart_data  in  2  ROM word, synchronous read, 1-cycle latency; bit1 = end-of-chart, bit0 = note present.
- good  out  1  one-cycle pulse: note hit inside its window.
- miss  out  1  one-cycle pulse: note window expired without a hit.
- done  out  1  one-cycle pulse: end of chart reached.
- score  out  SCORE_W  number of good hits.
- combo  out  8  current consecutive-hit count.

Behaviour:
- Reset (async, resetn=0):
  - state = IDLE.
  - chart_addr, score, combo, slot_cnt, win_cnt all = 0.
  - good, miss, done = 0.
- States: IDLE, FETCH, DECODE, OPEN, GAP, FINISH.
- IDLE:
  - chart_addr = 0.
  - On map=1: clear score, combo and counters; go to FETCH.
  - score and combo otherwise hold, so the result screen can display them.
- FETCH: one wait cycle for ROM latency, then DECODE.
- DECODE: samples chart_data.
  - bit1=1: go to FINISH and pulse done in the same cycle as the transition.
  - else bit0=1: go to OPEN, slot_cnt=0, win_cnt=0.
  - else: go to GAP, slot_cnt=0.
- OPEN (slot with a note):
  - Each tick increments slot_cnt and win_cnt.
  - hit: pulse good; score+1 saturating at all-ones; combo+1 saturating at 255; go to GAP.
  - tick with win_cnt==WINDOW-1 and no hit: pulse miss; combo=0; go to GAP.
  - hit and tick in the same cycle: hit wins, so good fires and miss does not.
- GAP (remainder of slot):
  - hit is ignored, with no penalty.
  - Each tick increments slot_cnt. slot_cnt continues from OPEN, so every slot lasts exactly TICKS_PER_SLOT ticks.
  - tick with slot_cnt==TICKS_PER_SLOT-1: chart_addr+1, go to FETCH.
- Address wrap: advancing from chart_addr = all-ones is treated as end of chart. chart_addr holds, done pulses, go to FINISH.
- FINISH: outputs and score hold; no further pulses; stays until map=0.
- map=0 in any non-IDLE state:
  - Next cycle goes to IDLE and sets chart_addr=0.
  - No good, miss or done is emitted in that cycle or later.
  - score and combo hold.
- Mutual exclusion:
  - good, miss and done are registered and mutually exclusive.
  - At most one pulse per note.
  - done never coincides with miss.
- Latency: good and miss are asserted on the cycle after the deciding hit/tick edge (registered outputs).

Test Plan:
1. Params TICKS_PER_SLOT=4, WINDOW=2. Chart = {01,00,10}, hit pulse 1 tick after slot 0 start -> one good, score=1, combo=1, no miss. done pulses once when address 2 is decoded, 8 ticks after start.
2. Same chart, no hits -> miss pulses exactly once, at the 2nd tick of slot 0; combo=0; done follows. The controller's miss counter sees exactly 1.
3. Chart of 7 notes, then end marker, no hits -> 7 miss pulses, 4 ticks apart. Drive map low after the 7th, as the controller loses -> IDLE, no done pulse, chart_addr=0.
4. hit and tick asserted in the same cycle as the closing window tick -> good=1, miss=0; hits during GAP -> no change to score or combo.
5. Assert resetn=0 mid-OPEN with score=3 -> all outputs 0 immediately, without waiting for a clock edge. After release with map=1 -> restarts at chart_addr=0.
6. Set ADDR_W=2 with chart entries 01 and no end marker -> after address 3 its slot completes; done pulses with chart_addr held at 3; FINISH holds until map=0.
